clken_nco: RTL



---
 rtl/clken_nco.sv | 118 +++++++++++
 1 files changed

// File: rtl/clken_nco.sv
// clken_nco: multi-channel NCO clock-enable generator.
// Strobes are held idle until the PLL lock has been qualified.
module clken_nco #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT =
        {NUM_CH{ACC_W'(32'h4000_0000)}},
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              locked_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              sync_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [ACC_W-1:0]  cfg_inc_i,
    output logic [NUM_CH-1:0] clken_o,
    output logic              ready_o
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lock_meta_q, lock_s_q;
    logic [ACC_W-1:0]   acc_q [NUM_CH];
    logic [ACC_W-1:0]   acc_d [NUM_CH];
    logic [ACC_W-1:0]   inc_q [NUM_CH];
    logic [ACC_W-1:0]   inc_d [NUM_CH];
    logic [ACC_W:0]     sum   [NUM_CH];
    logic [NUM_CH-1:0]  clken_q, clken_d;
    logic               run_go;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            clken_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= locked_i;
            lock_s_q    <= lock_meta_q;
            clken_q     <= clken_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
        end
    end

    // Transition fires on the edge where the count would reach LOCK_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (!lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_sum
            assign sum[g] = {1'b0, acc_q[g]} + {1'b0, inc_q[g]};
        end
    endgenerate

    // Sync and unlock both win over accumulation by zeroing run_go.
    always_comb begin
        run_go  = (state_q == RUN) && lock_s_q && !sync_i;
        clken_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = '0;
            inc_d[i] = inc_q[i];
            if (run_go && ch_en_i[i]) begin
                acc_d[i]   = sum[i][ACC_W-1:0];
                clken_d[i] = sum[i][ACC_W];
            end
            if (cfg_we_i && (cfg_ch_i == CH_W'(i))) begin
                inc_d[i] = cfg_inc_i;
            end
        end
    end

    always_comb begin
        ready_o = (state_q == RUN);
        clken_o = clken_q;
    end

endmodule
